im_fetch_unit: RTL and testbench

Instruction fetch initiator for the instruction memory: holds the fetch PC, drives the memory read address, and captures the combinational read data. Delivers each instruction word with its PC to decode over a valid/ready handshake through a 2-entry buffer. Sits between the instruction memory (window 0x76000000–0x760000FC, 64 words) and the decode stage. Supports PC redirect from branch/jump resolution, and flags fetches outside the memory window.

---
 rtl/im_fetch_if.sv | 43 ++++
 rtl/im_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_im_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/im_fetch_if.sv
// Fetch-unit bus bundle: instruction memory read port, redirect input,
// decode-side valid/ready handshake and performance counter outputs.
interface im_fetch_if;
    logic [31:0] im_addr_o;
    logic [31:0] im_rd_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        fault_o;
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_stall_o;

    modport master (
        output im_addr_o,
        input  im_rd_i,
        input  redirect_i,
        input  redirect_pc_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_o,
        output pc_o,
        output fault_o,
        output perf_fetch_o,
        output perf_stall_o
    );

    modport slave (
        input  im_addr_o,
        output im_rd_i,
        output redirect_i,
        output redirect_pc_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_o,
        input  pc_o,
        input  fault_o,
        input  perf_fetch_o,
        input  perf_stall_o
    );
endinterface

// File: rtl/im_fetch_unit.sv
// Instruction fetch initiator with a 2-entry {pc, instr, fault} buffer toward decode.
// Optional FETCH_PERF_EN macro enables the accepted-instruction and stall counters.
module im_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h7600_0000,
    parameter logic [23:0] IM_BASE  = 24'h760000
) (
    input logic         clk_i,
    input logic         rst_n_i,
    im_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PART  = 2'd1,
        FULL  = 2'd2
    } fill_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    fill_e       fill_q, fill_d;
    logic [31:0] fpc_q, fpc_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        halted_q, halted_d;
    entry_t      buf_q [2];
    entry_t      push_entry;
    logic        push;
    logic        pop;
    logic        fetch_fault;
    logic        valid;

    assign valid       = (fill_q != EMPTY);
    assign pop         = valid && bus.instr_ready_i;
    assign fetch_fault = (fpc_q[31:8] != IM_BASE) || (fpc_q[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fill_q   <= EMPTY;
            fpc_q    <= RESET_PC;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            halted_q <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            fill_q   <= fill_d;
            fpc_q    <= fpc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            halted_q <= halted_d;
            if (push) begin
                buf_q[wr_ptr_q] <= push_entry;
            end
        end
    end

    // Next-state logic; a redirect overrides any push and discards the buffer
    always_comb begin
        fill_d     = fill_q;
        fpc_d      = fpc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        halted_d   = halted_q;
        push       = 1'b0;
        push_entry = '0;

        if (bus.redirect_i) begin
            fill_d   = EMPTY;
            fpc_d    = bus.redirect_pc_i;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            halted_d = 1'b0;
        end else begin
            push = !halted_q && ((fill_q != FULL) || pop);
            if (push) begin
                wr_ptr_d = !wr_ptr_q;
                if (fetch_fault) begin
                    push_entry = '{pc: fpc_q, instr: 32'h0, fault: 1'b1};
                    halted_d   = 1'b1;
                end else begin
                    push_entry = '{pc: fpc_q, instr: bus.im_rd_i, fault: 1'b0};
                    fpc_d      = fpc_q + 32'd4;
                end
            end
            if (pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10: fill_d = (fill_q == EMPTY) ? PART : FULL;
                2'b01: fill_d = (fill_q == FULL) ? PART : EMPTY;
                default: fill_d = fill_q;
            endcase
        end
    end

    // Output logic
    always_comb begin
        bus.im_addr_o     = fpc_q;
        bus.instr_valid_o = valid;
        bus.instr_o       = '0;
        bus.pc_o          = '0;
        bus.fault_o       = 1'b0;
        if (valid) begin
            bus.instr_o = buf_q[rd_ptr_q].instr;
            bus.pc_o    = buf_q[rd_ptr_q].pc;
            bus.fault_o = buf_q[rd_ptr_q].fault;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (pop) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (valid && !bus.instr_ready_i) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign bus.perf_fetch_o = perf_fetch_q;
    assign bus.perf_stall_o = perf_stall_q;
`else
    assign bus.perf_fetch_o = '0;
    assign bus.perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_im_fetch_unit.sv
// Scoreboard bench for im_fetch_unit: expected {pc, instr, fault} entries are queued
// as stimulus is driven and compared on each decode handshake.
module tb_im_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem [64];
    exp_t        exp_q [$];
    int          total;
    int          bad;

    im_fetch_if bus ();

    im_fetch_unit #(
        .RESET_PC (32'h7600_0000),
        .IM_BASE  (24'h760000)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    assign bus.im_rd_i = mem[bus.im_addr_o[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.fault = fault;
        return e;
    endfunction

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst_n                  = 1'b0;
        bus.redirect_i         = 1'b0;
        bus.redirect_pc_i      = 32'h0;
        bus.instr_ready_i      = ready;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge with inputs set; compares each handshake against the queue head.
    task automatic drain(input int budget);
        exp_t e;
        for (int i = 0; i < budget; i++) begin
            if (bus.instr_valid_o && bus.instr_ready_i && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if ({bus.pc_o, bus.instr_o, bus.fault_o} !== {e.pc, e.instr, e.fault}) begin
                    bad++;
                    $display("FAIL entry: got pc=%h instr=%h fault=%b, want pc=%h instr=%h fault=%b",
                             bus.pc_o, bus.instr_o, bus.fault_o, e.pc, e.instr, e.fault);
                end
            end
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d entries still pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.instr_valid_o, bus.instr_o, bus.pc_o, bus.fault_o} !== 66'h0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b instr=%h pc=%h fault=%b, want all 0",
                     bus.instr_valid_o, bus.instr_o, bus.pc_o, bus.fault_o);
        end
        total++;
        if (bus.im_addr_o !== 32'h7600_0000) begin
            bad++;
            $display("FAIL reset_addr: got %h want 76000000", bus.im_addr_o);
        end
        total++;
        if ({bus.perf_fetch_o, bus.perf_stall_o} !== 64'h0) begin
            bad++;
            $display("FAIL reset_perf: got fetch=%0d stall=%0d want 0 0", bus.perf_fetch_o, bus.perf_stall_o);
        end
        // Asynchronous reset in the middle of a cycle with a full buffer
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.instr_valid_o !== 1'b0 || bus.im_addr_o !== 32'h7600_0000 || bus.pc_o !== 32'h0) begin
            bad++;
            $display("FAIL midreset: got valid=%b addr=%h pc=%h, want 0 76000000 0",
                     bus.instr_valid_o, bus.im_addr_o, bus.pc_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        do_reset(1'b1);
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(mk(32'h7600_0000 + 32'(4 * k), 32'h1000_0000 + 32'(k), 1'b0));
        end
        exp_q.push_back(mk(32'h7600_0100, 32'h0, 1'b1));
        drain(200);
        repeat (3) @(negedge clk);
        total++;
        if (bus.instr_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL wrap_halt_valid: got %b want 0", bus.instr_valid_o);
        end
        total++;
        if (bus.im_addr_o !== 32'h7600_0100) begin
            bad++;
            $display("FAIL wrap_halt_addr: got %h want 76000100", bus.im_addr_o);
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h7600_0000 || bus.instr_o !== 32'h1000_0000) begin
                bad++;
                $display("FAIL stall_head[%0d]: got valid=%b pc=%h instr=%h, want 1 76000000 10000000",
                         c, bus.instr_valid_o, bus.pc_o, bus.instr_o);
            end
        end
        total++;
        if (bus.im_addr_o !== 32'h7600_0008) begin
            bad++;
            $display("FAIL stall_addr: got %h want 76000008", bus.im_addr_o);
        end
        bus.instr_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(32'h7600_0000 + 32'(4 * k), 32'h1000_0000 + 32'(k), 1'b0));
        end
        drain(20);
    endtask

    task automatic test_redirect_full();
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        total++;
        if (bus.im_addr_o !== 32'h7600_0008 || bus.pc_o !== 32'h7600_0000) begin
            bad++;
            $display("FAIL full_before_redirect: got addr=%h pc=%h want 76000008 76000000",
                     bus.im_addr_o, bus.pc_o);
        end
        bus.instr_ready_i = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h7600_0040;
        @(negedge clk);
        bus.redirect_i = 1'b0;
        total++;
        if (bus.instr_valid_o !== 1'b0 || bus.im_addr_o !== 32'h7600_0040) begin
            bad++;
            $display("FAIL redirect_bubble: got valid=%b addr=%h want 0 76000040",
                     bus.instr_valid_o, bus.im_addr_o);
        end
        exp_q.push_back(mk(32'h7600_0040, 32'h1000_0010, 1'b0));
        exp_q.push_back(mk(32'h7600_0044, 32'h1000_0011, 1'b0));
        drain(10);
    endtask

    task automatic redirect_to(input logic [31:0] target);
        bus.instr_ready_i = 1'b0;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = target;
        @(negedge clk);
        bus.redirect_i    = 1'b0;
        bus.instr_ready_i = 1'b1;
    endtask

    task automatic check_halted(input logic [31:0] addr, input string name);
        repeat (3) @(negedge clk);
        total++;
        if (bus.instr_valid_o !== 1'b0 || bus.im_addr_o !== addr) begin
            bad++;
            $display("FAIL %s: got valid=%b addr=%h want 0 %h", name, bus.instr_valid_o, bus.im_addr_o, addr);
        end
    endtask

    task automatic test_redirect_outside();
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        redirect_to(32'h0000_1000);
        exp_q.push_back(mk(32'h0000_1000, 32'h0, 1'b1));
        drain(10);
        check_halted(32'h0000_1000, "outside_halt");
        redirect_to(32'h7600_0010);
        exp_q.push_back(mk(32'h7600_0010, 32'h1000_0004, 1'b0));
        exp_q.push_back(mk(32'h7600_0014, 32'h1000_0005, 1'b0));
        drain(10);
    endtask

    task automatic test_misaligned();
        do_reset(1'b1);
        repeat (2) @(negedge clk);
        redirect_to(32'h7600_0002);
        exp_q.push_back(mk(32'h7600_0002, 32'h0, 1'b1));
        drain(10);
        check_halted(32'h7600_0002, "misaligned_halt");
    endtask

    task automatic test_perf();
        int pops;
        int stalls;
        logic r;
        pops   = 0;
        stalls = 0;
        do_reset(1'b0);
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (pops == 10 && stalls == 3) break;
            if (pops >= 10)       r = 1'b0;
            else if (stalls >= 3) r = 1'b1;
            else                  r = cyc[0];
            bus.instr_ready_i = r;
            if (bus.instr_valid_o) begin
                if (r) pops++;
                else   stalls++;
            end
            @(negedge clk);
        end
`ifdef FETCH_PERF_EN
        total++;
        if (bus.perf_fetch_o !== 32'd10) begin
            bad++;
            $display("FAIL perf_fetch: got %0d want 10", bus.perf_fetch_o);
        end
        total++;
        if (bus.perf_stall_o !== 32'd3) begin
            bad++;
            $display("FAIL perf_stall: got %0d want 3", bus.perf_stall_o);
        end
`else
        total++;
        if ({bus.perf_fetch_o, bus.perf_stall_o} !== 64'h0) begin
            bad++;
            $display("FAIL perf_tied: got fetch=%0d stall=%0d want 0 0", bus.perf_fetch_o, bus.perf_stall_o);
        end
`endif
        total++;
        if (pops != 10 || stalls != 3) begin
            bad++;
            $display("FAIL perf_stimulus: got pops=%0d stalls=%0d want 10 3", pops, stalls);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.perf_fetch_o, bus.perf_stall_o} !== 64'h0) begin
            bad++;
            $display("FAIL perf_reset: got fetch=%0d stall=%0d want 0 0", bus.perf_fetch_o, bus.perf_stall_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        rst_n             = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.instr_ready_i = 1'b0;
        for (int k = 0; k < 64; k++) begin
            mem[k] = 32'h1000_0000 + 32'(k);
        end

        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_full();
        test_redirect_outside();
        test_misaligned();
        test_perf();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
